mant_norm_reg: RTL and testbench

//  Parametrised mantissa operand register for the IEEE-754 divider datapath.

---
 rtl/mant_norm_reg_if.sv | 18 +
 rtl/mant_norm_reg.sv | 65 ++++++
 tb/tb_mant_norm_reg.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mant_norm_reg_if.sv
// mant_norm_reg_if: control, data and status bundle of the mantissa normalising register
interface mant_norm_reg_if #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 5
);
  logic             ld;
  logic [WIDTH-1:0] in;
  logic             shl;
  logic             sin;
  logic             start_norm;
  logic [WIDTH-1:0] out;
  logic [CNT_W-1:0] shcnt;
  logic             busy;
  logic             done;
  logic             zero;
  modport master (output ld, in, shl, sin, start_norm, input out, shcnt, busy, done, zero);
  modport slave (input ld, in, shl, sin, start_norm, output out, shcnt, busy, done, zero);
endinterface

// File: rtl/mant_norm_reg.sv
// mant_norm_reg: mantissa register with load, serial shift-left and leading-zero normalisation
module mant_norm_reg #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 5
) (
  input logic clk,
  input logic rst,
  mant_norm_reg_if.slave bus
);
  typedef enum logic {IDLE, NORM} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] r, r_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             busy_r, done_r, done_n;
  always_comb begin
    state_n = state;
    r_n     = r;
    cnt_n   = cnt;
    done_n  = 1'b0;
    if (state == IDLE) begin
      if (bus.ld) begin
        r_n   = bus.in;
        cnt_n = '0;
      end else if (bus.start_norm) begin
        cnt_n = '0;
        // zero or already-normal operands finish without entering NORM
        if (r == '0 || r[WIDTH-1]) done_n = 1'b1;
        else state_n = NORM;
      end else if (bus.shl) begin
        r_n = {r[WIDTH-2:0], bus.sin};
      end
    end else if (bus.ld) begin
      r_n     = bus.in;
      cnt_n   = '0;
      state_n = IDLE;
    end else begin
      r_n   = r << 1;
      cnt_n = cnt + 1'b1;
      if (r[WIDTH-2]) begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      r      <= '0;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_n;
      r      <= r_n;
      cnt    <= cnt_n;
      busy_r <= state_n == NORM;
      done_r <= done_n;
    end
  end
  assign bus.out   = r;
  assign bus.shcnt = cnt;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.zero  = r == '0;
endmodule

// File: tb/tb_mant_norm_reg.sv
// tb_mant_norm_reg: randomized and directed checks of mant_norm_reg against a leading-zero model
module tb_mant_norm_reg;
  localparam int W  = 24;
  localparam int CW = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;
  mant_norm_reg_if #(.WIDTH(W), .CNT_W(CW)) bus ();
  mant_norm_reg #(.WIDTH(W), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic int clz(logic [W-1:0] v);
    for (int i = W - 1; i >= 0; i--) if (v[i]) return W - 1 - i;
    return W;
  endfunction

  task automatic idle_inputs();
    bus.ld = 1'b0; bus.in = '0; bus.shl = 1'b0; bus.sin = 1'b0; bus.start_norm = 1'b0;
  endtask

  task automatic load(logic [W-1:0] v);
    @(negedge clk);
    idle_inputs();
    bus.ld = 1'b1; bus.in = v;
    @(negedge clk);
    bus.ld = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #12;
    n_total++;
    if (bus.out !== '0 || bus.shcnt !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.zero !== 1'b1)
      $display("FAIL reset: out=%h shcnt=%0d busy=%b done=%b zero=%b, want 0 0 0 0 1",
               bus.out, bus.shcnt, bus.busy, bus.done, bus.zero);
    else n_pass++;
    @(posedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.out !== '0 || bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.zero !== 1'b1)
      $display("FAIL reset_release: out=%h done=%b busy=%b zero=%b", bus.out, bus.done, bus.busy, bus.zero);
    else n_pass++;
  endtask

  task automatic run_norm(string name, logic [W-1:0] op);
    int k = clz(op);
    int kk = (k == W) ? 0 : k;
    logic [W-1:0] exp_out = (k == W) ? '0 : op << k;
    int busy_cycles = 0;
    load(op);
    bus.start_norm = 1'b1;
    @(negedge clk);
    bus.start_norm = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      if (bus.done) break;
      if (bus.busy) busy_cycles++;
      @(negedge clk);
    end
    n_total++;
    if (bus.done !== 1'b1 || busy_cycles != kk || bus.out !== exp_out || bus.shcnt !== CW'(kk) ||
        bus.zero !== (op == '0) || bus.busy !== 1'b0)
      $display("FAIL %s op=%h: done=%b busy_cycles=%0d out=%h shcnt=%0d zero=%b, want 1 %0d %h %0d %b",
               name, op, bus.done, busy_cycles, bus.out, bus.shcnt, bus.zero, kk, exp_out, kk, op == '0);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (bus.done !== 1'b0 || bus.out !== exp_out || bus.shcnt !== CW'(kk))
      $display("FAIL %s_hold: done=%b out=%h shcnt=%0d, want 0 %h %0d", name, bus.done, bus.out, bus.shcnt, exp_out, kk);
    else n_pass++;
  endtask

  task automatic test_directed_norm();
    run_norm("norm_123", 24'h000123);
    run_norm("norm_msb", 24'h800000);
    run_norm("norm_zero", 24'h000000);
    run_norm("norm_one", 24'h000001);
  endtask

  task automatic test_random_norm();
    for (int t = 0; t < 20; t++) begin
      logic [W-1:0] r = W'($urandom);
      run_norm("norm_rand", r >> $urandom_range(0, W - 1));
    end
  endtask

  task automatic test_abort();
    bit saw_done = 0;
    load(24'h000001);
    bus.start_norm = 1'b1;
    @(negedge clk);
    bus.start_norm = 1'b0;
    for (int i = 1; i < 5; i++) begin
      saw_done |= bus.done;
      @(negedge clk);
    end
    bus.ld = 1'b1; bus.in = 24'hABCDEF;
    @(negedge clk);
    bus.ld = 1'b0;
    saw_done |= bus.done;
    n_total++;
    if (bus.out !== 24'hABCDEF || bus.shcnt !== '0 || bus.busy !== 1'b0 || saw_done)
      $display("FAIL abort: out=%h shcnt=%0d busy=%b saw_done=%b, want abcdef 0 0 0",
               bus.out, bus.shcnt, bus.busy, saw_done);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (bus.done !== 1'b0 || bus.out !== 24'hABCDEF)
      $display("FAIL abort_after: done=%b out=%h, want 0 abcdef", bus.done, bus.out);
    else n_pass++;
  endtask

  task automatic test_shl();
    logic [W-1:0] m;
    load(24'h400000);
    bus.shl = 1'b1; bus.sin = 1'b1;
    @(negedge clk);
    bus.shl = 1'b0;
    n_total++;
    if (bus.out !== 24'h800001 || bus.shcnt !== '0)
      $display("FAIL shl_basic: out=%h shcnt=%0d, want 800001 0", bus.out, bus.shcnt);
    else n_pass++;
    m = W'($urandom);
    load(m);
    for (int i = 0; i < 30; i++) begin
      bus.shl = 1'($urandom); bus.sin = 1'($urandom);
      if (bus.shl) m = {m[W-2:0], bus.sin};
      @(negedge clk);
    end
    bus.shl = 1'b0;
    n_total++;
    if (bus.out !== m) $display("FAIL shl_random: out=%h, want %h", bus.out, m);
    else n_pass++;
    bus.ld = 1'b1; bus.in = 24'h123456; bus.shl = 1'b1; bus.sin = 1'b1;
    @(negedge clk);
    idle_inputs();
    n_total++;
    if (bus.out !== 24'h123456) $display("FAIL ld_over_shl: out=%h, want 123456", bus.out);
    else n_pass++;
  endtask

  task automatic test_rst_mid_norm();
    bit saw_done = 0;
    load(24'h000010);
    bus.start_norm = 1'b1;
    @(negedge clk);
    bus.start_norm = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_total++;
    if (bus.out !== '0 || bus.shcnt !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.zero !== 1'b1)
      $display("FAIL rst_mid_norm: out=%h shcnt=%0d busy=%b done=%b zero=%b, want 0 0 0 0 1",
               bus.out, bus.shcnt, bus.busy, bus.done, bus.zero);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      saw_done |= bus.done | bus.busy;
    end
    n_total++;
    if (saw_done || bus.out !== '0) $display("FAIL rst_mid_norm_after: activity=%b out=%h, want 0 0", saw_done, bus.out);
    else n_pass++;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_directed_norm();
    test_abort();
    test_shl();
    test_random_norm();
    test_rst_mid_norm();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
